// File: rtl/d2lib_pkg.sv
// rtl/d2lib_pkg.sv - shared D2 cell-library mode encodings and default parameters
`timescale 1ns/1ps
package d2lib_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    SHL  = 3'd1,
    SHR  = 3'd2,
    LOAD = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5,
    UP   = 3'd6,
    DOWN = 3'd7
  } mode_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DELAY = 2;

endpackage

// File: rtl/usr_bit.sv
// rtl/usr_bit.sv - one bit slice of univ_shift_reg (mode mux, flop, carry/borrow); timing via UNIV_SHIFT_REG_TIMING_EN
`timescale 1ns/1ps
module usr_bit
  import d2lib_pkg::*;
`ifdef UNIV_SHIFT_REG_TIMING_EN
#(
  parameter int DELAY = DEFAULT_DELAY
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] mode,
  input  logic       d,
  input  logic       from_lo,
  input  logic       from_hi,
  input  logic       ci,
  input  logic       bi,
  output logic       q,
  output logic       qn,
  output logic       co,
  output logic       bo
);

  logic q_next;

  // Next-state mux; shifts and rotates share a path because the top muxes the end bits
  always_comb begin
    q_next = q;
    if (en) begin
      case (mode_e'(mode))
        HOLD:     q_next = q;
        SHL, ROL: q_next = from_lo;
        SHR, ROR: q_next = from_hi;
        LOAD:     q_next = d;
        UP:       q_next = q ^ ci;
        DOWN:     q_next = q ^ bi;
        default:  q_next = q;
      endcase
    end
  end

  // Carry out when this and all lower bits are ones; borrow out when all are zeros
  always_comb begin
    co = q & ci;
    bo = ~q & bi;
  end

  // Complement is derived from the flop, never stored separately
  assign qn = ~q;

`ifdef UNIV_SHIFT_REG_TIMING_EN
  // State flop with synchronous active-high reset and modelled clock-to-output delay
  always_ff @(posedge clk) begin
    if (rst) q <= #DELAY 1'b0;
    else     q <= #DELAY q_next;
  end
`else
  // State flop with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= q_next;
  end
`endif

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal hold/shift/rotate/load/count register; timing via UNIV_SHIFT_REG_TIMING_EN
`timescale 1ns/1ps
module univ_shift_reg
  import d2lib_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DELAY = DEFAULT_DELAY
)
(
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic [2:0]       M,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SOL,
  output logic             SOR,
  output logic             TC
);

  if (WIDTH < 2 || WIDTH > 32 || DELAY < 0) begin : g_param_check
    $error("univ_shift_reg: WIDTH must be 2..32 and DELAY non-negative");
  end

  logic             sil_mux;
  logic             sir_mux;
  logic [WIDTH-1:0] lo_in;
  logic [WIDTH-1:0] hi_in;

  // End-slice serial inputs: rotate feeds back the opposite end, shift takes the pin
  always_comb begin
    sil_mux = (M == ROL) ? Q[WIDTH-1] : SIL;
    sir_mux = (M == ROR) ? Q[0]       : SIR;
    lo_in   = {Q[WIDTH-2:0], sil_mux};
    hi_in   = {sir_mux, Q[WIDTH-1:1]};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ci_w;
    logic bi_w;
    logic co_w;
    logic bo_w;

    if (i == 0) begin : g_first
      assign ci_w = 1'b1;
      assign bi_w = 1'b1;
    end else begin : g_rest
      assign ci_w = g_bit[i-1].co_w;
      assign bi_w = g_bit[i-1].bo_w;
    end

    usr_bit
`ifdef UNIV_SHIFT_REG_TIMING_EN
      #(.DELAY(DELAY))
`endif
      u_bit (
        .clk     (C),
        .rst     (R),
        .en      (EN),
        .mode    (M),
        .d       (D[i]),
        .from_lo (lo_in[i]),
        .from_hi (hi_in[i]),
        .ci      (ci_w),
        .bi      (bi_w),
        .q       (Q[i]),
        .qn      (QN[i]),
        .co      (co_w),
        .bo      (bo_w)
      );
  end

  // Terminal count reuses the ripple ends: final carry means all ones, final borrow all zeros
  always_comb begin
    SOL = Q[WIDTH-1];
    SOR = Q[0];
    TC  = EN & (((M == UP)   & g_bit[WIDTH-1].co_w) |
                ((M == DOWN) & g_bit[WIDTH-1].bo_w));
  end

`ifdef UNIV_SHIFT_REG_TIMING_EN
  specify
    $setuphold(posedge C, D,   1, 2);
    $setuphold(posedge C, SIL, 1, 2);
    $setuphold(posedge C, SIR, 1, 2);
    $setuphold(posedge C, M,   1, 2);
    $setuphold(posedge C, EN,  1, 2);
    $setuphold(posedge C, R,   1, 2);
  endspecify
`endif

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal register for the D2 cell library. It is a WIDTH-bit bank of flip-flops with complementary outputs, built on the single-bit D-type flop. Per cycle it can hold, shift, rotate, parallel-load or count, and it flags terminal count. It is the standard storage/sequencing element for D2 datapaths: counters, serial links and pipeline registers.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- DELAY, 2, clock-to-output delay in ns; applied only when timing is compiled in.

Ports:
- C  input  1  clock; all state changes on its rising edge.
- R  input  1  reset; synchronous, active-high.
- EN  input  1  cycle enable; 0 forces hold regardless of M.
- M  input  3  mode select (encodings under Operation).
- D  input  WIDTH  parallel load data.
- SIL  input  1  serial in, enters bit 0 on shift left.
- SIR  input  1  serial in, enters bit WIDTH-1 on shift right.
- Q  output  WIDTH  register state.
- QN  output  WIDTH  bitwise complement of Q, always.
- SOL  output  1  Q[WIDTH-1] (serial out, left).
- SOR  output  1  Q[0] (serial out, right).
- TC  output  1  terminal count, combinational.

## Operation
- Reset value: Q = 0, QN = all ones, SOL = 0, SOR = 0, TC = 0.
- Priority at each rising C: R, then EN = 0 (hold), then M.
- M = 0 HOLD: Q unchanged.
- M = 1 SHL: Q <= {Q[WIDTH-2:0], SIL}.
- M = 2 SHR: Q <= {SIR, Q[WIDTH-1:1]}.
- M = 3 LOAD: Q <= D.
- M = 4 ROL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}. SIL is ignored.
- M = 5 ROR: Q <= {Q[0], Q[WIDTH-1:1]}. SIR is ignored.
- M = 6 UP: Q <= Q + 1, modulo 2^WIDTH. All ones wraps to 0.
- M = 7 DOWN: Q <= Q - 1, modulo 2^WIDTH. 0 wraps to all ones.
- TC = EN & ((M == UP & Q == all ones) | (M == DOWN & Q == 0)). TC therefore marks the cycle whose edge wraps Q.
- No internal state beyond Q. There is no mode FSM, and a mode change takes effect on the next edge.
- QN is never stored independently of Q. No X is permitted on QN after reset.

## Timing
- Latency: one edge. The value selected by R/EN/M/D/SIL/SIR before edge n appears on Q after edge n, plus DELAY when timing is compiled in.
- R held high over an edge always yields Q = 0, even mid-count or mid-shift. R has no effect between edges.
- R deasserted with EN = 1 and M = UP: first increment occurs on the next edge, giving Q = 1.
- SOL, SOR, QN and TC follow Q combinationally, with no extra delay. TC also follows EN and M combinationally.
- Simultaneous R and EN = 1 with any M: reset wins.

## Configuration
- UNIV_SHIFT_REG_TIMING_EN defined:
  - Q and QN update with nonblocking #DELAY.
  - A specify block checks $setuphold(posedge C, D/SIL/SIR/M/EN/R, 1, 2), i.e. 1 ns setup and 2 ns hold. Violations are reported by the simulator.
- Undefined: zero-delay updates and no specify block. Functional behaviour is otherwise identical.

## Structure
- Shared package d2lib_pkg holds:
  - the mode typedef/constants HOLD, SHL, SHR, LOAD, ROL, ROR, UP, DOWN (3-bit);
  - default WIDTH and DELAY constants.
- Sub-module usr_bit: one bit slice containing the 8:1 next-state mux and a flop with synchronous active-high reset. It takes neighbour bits, D bit and carry/borrow in, and gives Q, QN and carry/borrow out.
- Top level: instantiates WIDTH slices, ripples carry/borrow, muxes the serial inputs into the end slices, and forms TC.

## Test plan
Each scenario below uses WIDTH = 8.
- Reset: R = 1 for 2 edges with M = UP, EN = 1 -> Q = 8'h00, QN = 8'hFF, TC = 0. Then R = 0 for 3 edges -> Q = 8'h03.
- Load/hold:
  - M = LOAD, D = 8'hA5, one edge -> Q = 8'hA5, QN = 8'h5A, SOL = 1, SOR = 1.
  - Then EN = 0 with M = SHL for 4 edges -> Q stays 8'hA5.
- Shifts:
  - From Q = 8'hA5, M = SHL, SIL = 0, one edge -> Q = 8'h4A.
  - Then M = SHR, SIR = 1 -> Q = 8'hA5.
  - Then ROL -> Q = 8'h4B.
  - Then ROR -> Q = 8'hA5.
- Count wrap:
  - Load 8'hFE, M = UP -> TC = 0. Next edge gives Q = 8'hFF with TC = 1. Next edge gives Q = 8'h00 with TC = 0.
  - Then M = DOWN -> TC = 1 immediately. Next edge gives Q = 8'hFF.
- Reset mid-operation: count up from 8'h10, assert R for one edge at Q = 8'h13 -> Q = 8'h00 on that edge. Counting resumes at 8'h01.
- With UNIV_SHIFT_REG_TIMING_EN: change D 0.5 ns before a LOAD edge -> setup violation reported. Also check that Q changes exactly DELAY ns after the edge.
